// File: rtl/attention_token_precision.sv
// Column-sums a softmax attention matrix over queries/heads and maps each key token to a precision code.
// Latency: done/out_valid rise 2L+1 edges after start is accepted; start is ignored while busy.
module attention_token_precision #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
  input  logic [ACC_WIDTH-1:0]           thr_lo,
  input  logic [ACC_WIDTH-1:0]           thr_hi,
  output logic                           busy,
  output logic [3:0]                     token_precision [0:L-1],
  output logic                           done,
  output logic                           out_valid
);
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int SW = ACC_WIDTH + $clog2(N) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CLASS, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [DATA_WIDTH*L*N*L-1:0] r_a;
  logic [ACC_WIDTH-1:0]        r_lo, r_hi;
  logic [ACC_WIDTH-1:0]        r_sum [0:L-1];
  logic [CW-1:0]               r_r, r_t;

  logic [SW-1:0]               w_col_add [0:L-1];
  logic [ACC_WIDTH-1:0]        w_col_sat [0:L-1];
  logic [ACC_WIDTH-1:0]        w_sum_t;
  logic [3:0]                  w_code;
  logic                        w_r_last, w_t_last;

  assign busy     = (r_state != S_IDLE);
  assign w_r_last = (r_r == CW'(L-1));
  assign w_t_last = (r_t == CW'(L-1));

  // Wide intermediate sum so the row contribution cannot wrap before saturation.
  always_comb begin
    for (int c = 0; c < L; c++) begin
      w_col_add[c] = SW'(r_sum[c]);
      for (int n = 0; n < N; n++) begin
        w_col_add[c] = w_col_add[c] +
          SW'(r_a[((int'(r_r)*N*L) + (n*L) + c)*DATA_WIDTH +: DATA_WIDTH]);
      end
      w_col_sat[c] = (w_col_add[c] > SW'(ACC_MAX)) ? ACC_MAX : w_col_add[c][ACC_WIDTH-1:0];
    end
  end

  // High threshold is tested first so it wins when thr_lo > thr_hi.
  always_comb begin
    w_sum_t = r_sum[r_t];
    if (w_sum_t >= r_hi)      w_code = 4'd2;
    else if (w_sum_t >= r_lo) w_code = 4'd1;
    else                      w_code = 4'd0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)    w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_r_last) w_state_nxt = S_CLASS;
      S_CLASS: if (w_t_last) w_state_nxt = S_DONE;
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_r       <= '0;
      r_t       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < L; i++) begin
        r_sum[i]           <= '0;
        token_precision[i] <= 4'd2;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= A_in;
            r_lo      <= thr_lo;
            r_hi      <= thr_hi;
            r_r       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < L; i++) r_sum[i] <= '0;
          end
        end
        S_ACCUM: begin
          for (int c = 0; c < L; c++) r_sum[c] <= w_col_sat[c];
          r_r <= r_r + CW'(1);
          if (w_r_last) r_t <= '0;
        end
        S_CLASS: begin
          token_precision[r_t] <= w_code;
          r_t <= r_t + CW'(1);
        end
        S_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
